// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU front-end definitions: datapath widths, reset PC, PC increment,
// the instruction-fetch state encoding and a counter-width helper.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package cpu_pkg;

    localparam int          ADDR_W   = 32;
    localparam int          INST_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    // Bits needed to hold a count in the range 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding fetched {instruction, pc} words. The head entry is
// presented combinationally from the storage registers (no write-through), so
// a pushed word becomes visible on the cycle after the push.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clear         synchronous flush (drops all entries)
//   push, wdata   write request and data
//   pop           remove head entry (ignored when empty)
//   rdata         head entry
//   full, empty   occupancy flags
//   count         number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer advance with wrap for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
        do_push_s = push && ((count_r != CNT_MAX) || do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (clear) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (count_r == CNT_MAX);
    assign empty = (count_r == {CNT_W{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch unit: owns the PC, issues word reads to instruction memory
// under a credit limit (in-flight + queued <= DEPTH), queues returned words in
// a FIFO and hands {inst, inst_pc} to the decoder over valid/ready. A redirect
// flushes the queue, reloads the PC and discards every word still in flight.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req/addr/gnt         read request channel (addr is the PC)
//   imem_rvalid/rdata         in-order read return channel
//   inst, inst_pc, inst_valid decoder output, inst_ready its accept
//   redirect, redirect_pc     one-cycle flush-and-refetch request
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                INST_W   = cpu_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC),
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int                CNT_W   = cnt_w(DEPTH);
    localparam logic [CNT_W:0]    CREDITS = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN   = ~ADDR_W'(32'd3);

    fetch_state_e      state_r;
    fetch_state_e      state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] resp_pc_r;
    logic [ADDR_W-1:0] redir_pc_s;
    logic [CNT_W-1:0]  outstanding_r;
    logic [CNT_W-1:0]  outstanding_nxt_s;
    logic [CNT_W-1:0]  drop_cnt_r;
    logic [CNT_W-1:0]  drop_cnt_nxt_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [CNT_W:0]    inflight_s;
    logic              req_s;
    logic              grant_s;
    logic              rvalid_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [INST_W+ADDR_W-1:0] fifo_rdata_s;

    // Credit check, handshakes and counter arithmetic shared by FSM and datapath.
    always_comb begin
        redir_pc_s        = redirect_pc & ALIGN;
        inflight_s        = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
        req_s             = (state_r == FETCH) && (inflight_s < CREDITS);
        grant_s           = req_s && imem_gnt;
        // Returns with nothing outstanding belong to requests lost to a reset.
        rvalid_s          = imem_rvalid && (outstanding_r != {CNT_W{1'b0}});
        push_s            = rvalid_s && (state_r == FETCH) && !redirect;
        pop_s             = !fifo_empty_s && inst_ready;
        outstanding_nxt_s = outstanding_r + CNT_W'(grant_s) - CNT_W'(rvalid_s);
    end

    // Stale-word counter: on redirect everything still in flight after this
    // edge (including a same-cycle grant, minus a same-cycle return) is stale.
    always_comb begin
        drop_cnt_nxt_s = drop_cnt_r;
        if (redirect) begin
            drop_cnt_nxt_s = outstanding_nxt_s;
        end else if ((state_r == FLUSH) && rvalid_s && (drop_cnt_r != {CNT_W{1'b0}})) begin
            drop_cnt_nxt_s = drop_cnt_r - CNT_W'(1);
        end else begin
            drop_cnt_nxt_s = drop_cnt_r;
        end
    end

    // Next-state logic; FLUSH is left on the edge where the last stale word drains.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                state_nxt_s = FETCH;
            end
            FETCH, FLUSH: begin
                if (redirect || (state_r == FLUSH)) begin
                    state_nxt_s = (drop_cnt_nxt_s != {CNT_W{1'b0}}) ? FLUSH : FETCH;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register, PCs and in-flight counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            pc_r          <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= {CNT_W{1'b0}};
            drop_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            drop_cnt_r    <= drop_cnt_nxt_s;
            if (redirect) begin
                pc_r      <= redir_pc_s;
                resp_pc_r <= redir_pc_s;
            end else begin
                if (grant_s) begin
                    pc_r <= pc_r + STEP;
                end
                if (push_s) begin
                    resp_pc_r <= resp_pc_r + STEP;
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (INST_W + ADDR_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect),
        .push  (push_s),
        .wdata ({imem_rdata, resp_pc_r}),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // The full flag is implied by the credit count; it is kept for observability.
    logic unused_full_s;
    assign unused_full_s = fifo_full_s;

    assign imem_req   = req_s;
    assign imem_addr  = pc_r;
    assign inst       = fifo_rdata_s[INST_W+ADDR_W-1:ADDR_W];
    assign inst_pc    = fifo_rdata_s[ADDR_W-1:0];
    assign inst_valid = !fifo_empty_s;

endmodule

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inst_fetch #(
        .ADDR_W   (32),
        .INST_W   (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_1111;
    endfunction

    // Memory model: in-order returns, latency counted from grant.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        q[$];
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_issue = 32'h0;
    int          n_hs = 0;

    // Return driver: acts just after each rising edge.
    initial begin
        req_t r;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0 && q[0].due <= cyc) begin
                r = q.pop_front();
                imem_rvalid = 1'b1;
                imem_rdata  = memdata(r.addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    // Grant recorder and output scoreboard, sampled on the falling edge.
    initial begin
        req_t r;
        forever begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin
                if (!rst) begin
                    chk("issue_addr", imem_addr, exp_issue);
                    exp_issue = exp_issue + 32'd4;
                end
                r.addr = imem_addr;
                r.due  = cyc + lat;
                if (q.size() > 0 && r.due < q[q.size()-1].due) r.due = q[q.size()-1].due;
                q.push_back(r);
            end
            if (!rst && inst_valid && inst_ready) begin
                chk("inst_pc", inst_pc, exp_pc);
                chk("inst_data", inst, memdata(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_hs++;
            end
            if (redirect) begin
                exp_pc    = redirect_pc & 32'hFFFF_FFFC;
                exp_issue = redirect_pc & 32'hFFFF_FFFC;
            end
            if (rst) begin
                exp_pc    = 32'h0;
                exp_issue = 32'h0;
            end
        end
    end

    // Advance n rising edges; returns just after the memory model has driven.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req},   32'd0);
        chk({tag, "_addr"},  imem_addr,           32'h0);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_inst"},  inst,                32'h0);
        chk({tag, "_pc"},    inst_pc,             32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] h_pc;
        logic [31:0] h_inst;
        int          hs0;
        bit          found;
        bit          saw_valid;

        rst = 1'b1; imem_gnt = 1'b0; inst_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;
        tick(3);
        @(negedge clk);
        chk_reset_outputs("reset");

        // Release reset: one IDLE cycle, then fetch from 0.
        tick(1);
        rst = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b1; lat = 1;
        @(negedge clk);
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        tick(1);
        @(negedge clk);
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);

        // Streaming, order checked by the scoreboard.
        tick(20);
        chk("t1_progress", {31'd0, n_hs >= 8}, 32'd1);

        // Back-pressure: queue fills, request drops, head holds.
        inst_ready = 1'b0;
        tick(8);
        @(negedge clk);
        chk("t2_req_off", {31'd0, imem_req}, 32'd0);
        chk("t2_valid", {31'd0, inst_valid}, 32'd1);
        chk("t2_head_pc", inst_pc, exp_pc);
        h_pc = inst_pc; h_inst = inst;
        tick(3);
        @(negedge clk);
        chk("t2_hold_pc", inst_pc, h_pc);
        chk("t2_hold_inst", inst, h_inst);
        chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
        tick(1);
        hs0 = n_hs; inst_ready = 1'b1; imem_gnt = 1'b0;
        tick(2);
        @(negedge clk);
        chk("t2_queued_count", n_hs - hs0, 32'd2);
        chk("t2_empty", {31'd0, inst_valid}, 32'd0);
        tick(1);
        imem_gnt = 1'b1;

        // Redirect with two requests in flight.
        lat = 4;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (q.size() == 2 && !inst_valid && !imem_rvalid) begin
                found = 1'b1;
                break;
            end
        end
        chk("t3_setup", {31'd0, found}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick(1);
        redirect = 1'b0;
        @(negedge clk);
        chk("t3_flush_req", {31'd0, imem_req}, 32'd0);
        chk("t3_flush_addr", imem_addr, 32'h0000_0100);
        chk("t3_flush_valid", {31'd0, inst_valid}, 32'd0);
        found = 1'b0; saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (imem_req) begin
                found = 1'b1;
                break;
            end
            saw_valid |= inst_valid;
        end
        chk("t3_refetch", {31'd0, found}, 32'd1);
        chk("t3_refetch_addr", imem_addr, 32'h0000_0100);
        chk("t3_drained", q.size(), 32'd0);
        chk("t3_no_stale", {31'd0, saw_valid}, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (inst_valid) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        chk("t3_first_valid", {31'd0, found}, 32'd1);
        chk("t3_first_pc", inst_pc, 32'h0000_0100);

        // Redirect in the same cycle as a grant and a return.
        lat = 1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (imem_req && imem_gnt && imem_rvalid) begin
                found = 1'b1;
                break;
            end
        end
        chk("t4_setup", {31'd0, found}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick(1);
        redirect = 1'b0;
        @(negedge clk);
        chk("t4_flush_req", {31'd0, imem_req}, 32'd0);
        chk("t4_flush_valid", {31'd0, inst_valid}, 32'd0);
        chk("t4_flush_addr", imem_addr, 32'h0000_0200);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (imem_req) begin
                found = 1'b1;
                break;
            end
        end
        chk("t4_refetch", {31'd0, found}, 32'd1);
        chk("t4_refetch_addr", imem_addr, 32'h0000_0200);
        chk("t4_drained", q.size(), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        chk("t4_first_pc", inst_pc, 32'h0000_0200);
        chk("t4_first_inst", inst, memdata(32'h0000_0200));

        // PC wrap at the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick(1);
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (imem_req && imem_addr == 32'hFFFF_FFFC) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_reach_top", {31'd0, found}, 32'd1);
        tick(1);
        chk("t5_wrap", imem_addr, 32'h0000_0000);
        tick(10);

        // Reset mid-fetch with returns pending.
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (q.size() >= 1) begin
                found = 1'b1;
                break;
            end
        end
        chk("t6_setup", {31'd0, found}, 32'd1);
        rst = 1'b1; imem_gnt = 1'b0;
        tick(1);
        @(negedge clk);
        chk_reset_outputs("t6_reset");
        tick(1);
        rst = 1'b0;
        found = 1'b0; saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            saw_valid |= inst_valid;
            if (q.size() == 0 && !imem_rvalid) begin
                found = 1'b1;
                break;
            end
        end
        chk("t6_late_done", {31'd0, found}, 32'd1);
        chk("t6_late_ignored", {31'd0, saw_valid}, 32'd0);
        chk("t6_refetch_addr", imem_addr, 32'h0000_0000);
        imem_gnt = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (inst_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("t6_first_valid", {31'd0, found}, 32'd1);
        chk("t6_first_pc", inst_pc, 32'h0000_0000);
        tick(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
